quad_step_decoder: RTL



---
 rtl/quad_step_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronises and glitch-filters both encoder lines, then issues count/direction commands.
// Build option QDEC_X1_EN selects x1 decoding (one act per full cycle); the default build is x4 decoding.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_N      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       en,
    input  logic       clr_err,
    output logic       act,
    output logic       up_dn,
    output logic       err,
    output logic       err_flag,
    output logic [1:0] phase
);

    localparam int CW     = $clog2(FILT_N + 1);
    localparam int SETTLE = SYNC_STAGES + FILT_N + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        INIT = 3'd0,
        P00  = 3'd1,
        P01  = 3'd2,
        P11  = 3'd3,
        P10  = 3'd4
    } state_t;

    function automatic logic [1:0] state_phase(input state_t s);
        logic [1:0] p;
        case (s)
            P00:     p = 2'b00;
            P01:     p = 2'b01;
            P11:     p = 2'b11;
            P10:     p = 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    function automatic state_t phase_state(input logic [1:0] p);
        state_t s;
        case (p)
            2'b00:   s = P00;
            2'b01:   s = P01;
            2'b11:   s = P11;
            2'b10:   s = P10;
            default: s = P00;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] next_up(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            2'b10:   n = 2'b00;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {enc_b, enc_a};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CW-1:0]          r_cnt;
        logic                   r_filt;
        logic                   w_sync;

        // Plain flop chain into the clock domain
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
            end
        end

        assign w_sync = r_sync[SYNC_STAGES-1];

        // Accept a new level only after FILT_N consecutive differing samples
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else if (w_sync == r_filt) begin
                r_cnt  <= '0;
            end else if (r_cnt == CW'(FILT_N - 1)) begin
                r_cnt  <= '0;
                r_filt <= w_sync;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end

        assign w_filt[g] = r_filt;
    end

    state_t         r_state;
    state_t         w_state_nx;
    logic [SW-1:0]  r_settle;
    logic           r_act;
    logic           r_up_dn;
    logic           r_err;
    logic           r_err_flag;
    logic           w_act_nx;
    logic           w_up_dn_nx;
    logic           w_err_nx;
    logic           w_cnt_step;
    logic [1:0]     w_cur;
    logic [1:0]     w_diff;

    // Settle counter: lets the pipeline fill before phase tracking starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle <= '0;
        end else if ((r_state == INIT) && (r_settle != SW'(SETTLE - 1))) begin
            r_settle <= r_settle + SW'(1);
        end else begin
            r_settle <= r_settle;
        end
    end

    // State and registered command outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_act   <= 1'b0;
            r_up_dn <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_act   <= w_act_nx;
            r_up_dn <= w_up_dn_nx;
            r_err   <= w_err_nx;
        end
    end

    // Sticky error: a pending err pulse beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_flag <= 1'b0;
        end else if (r_err) begin
            r_err_flag <= 1'b1;
        end else if (clr_err) begin
            r_err_flag <= 1'b0;
        end else begin
            r_err_flag <= r_err_flag;
        end
    end

    // Next-state decode: the state always follows the filtered phase
    always_comb begin
        w_state_nx = r_state;
        w_act_nx   = 1'b0;
        w_up_dn_nx = r_up_dn;
        w_err_nx   = 1'b0;
        w_cur      = state_phase(r_state);
        w_diff     = w_filt ^ w_cur;
`ifdef QDEC_X1_EN
        w_cnt_step = (w_filt == 2'b00);
`else
        w_cnt_step = 1'b1;
`endif
        case (r_state)
            INIT: begin
                if (r_settle == SW'(SETTLE - 1)) begin
                    w_state_nx = phase_state(w_filt);
                end else begin
                    w_state_nx = INIT;
                end
            end
            P00, P01, P11, P10: begin
                w_state_nx = phase_state(w_filt);
                if (w_diff == 2'b11) begin
                    w_err_nx = 1'b1;
                end else if (w_diff != 2'b00) begin
                    w_up_dn_nx = (w_filt == next_up(w_cur));
                    w_act_nx   = en & w_cnt_step;
                end else begin
                    w_act_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = INIT;
            end
        endcase
    end

    assign act      = r_act;
    assign up_dn    = r_up_dn;
    assign err      = r_err;
    assign err_flag = r_err_flag;
    assign phase    = w_filt;

endmodule
